// File: rtl/jesd_tx_pkg.sv
// jesd_tx_pkg: shared state encodings, lane mux codes and JESD204B timing constants
package jesd_tx_pkg;
    typedef enum logic [2:0] {
        ST_SYNC      = 3'b001,
        ST_INIT_LANE = 3'b010,
        ST_DATA_ENC  = 3'b100
    } state_t;
    localparam logic [2:0] SEND_USER_DATA     = 3'd0;
    localparam logic [2:0] SEND_K             = 3'd1;
    localparam logic [2:0] SEND_LANE_SEQ      = 3'd2;
    localparam logic [2:0] SEND_LINK_TEST_SEQ = 3'd3;
    localparam int K_EXTRA_OCTETS = 9;
    localparam int REINIT_FRAMES  = 5;
endpackage

// File: rtl/jesd_sync_n_monitor.sv
// jesd_sync_n_monitor: SYNC~ low-time tracking, reinit request and short-assertion error counting
//   i_active        link is in INIT_LANE or DATA_ENC
//   i_sync_n        synchronised SYNC~
//   i_cfg_f         latched octets-per-frame minus 1
//   o_reinit        SYNC~ has been low for 5*F+9 cycles
//   o_sync_err      one-cycle pulse per short SYNC~ assertion
//   o_sync_err_cnt  saturating count of error pulses
module jesd_sync_n_monitor
    import jesd_tx_pkg::*;
#(
    parameter int F_MAX     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_active,
    input  logic                       i_sync_n,
    input  logic [$clog2(F_MAX)-1:0]   i_cfg_f,
    output logic                       o_reinit,
    output logic                       o_sync_err,
    output logic [ERR_CNT_W-1:0]       o_sync_err_cnt
);
    localparam int LW = $clog2(REINIT_FRAMES * F_MAX + K_EXTRA_OCTETS + 1);
    logic [LW-1:0] low_cnt, thresh;
    logic short_err;
    assign thresh    = LW'(REINIT_FRAMES * (int'(i_cfg_f) + 1) + K_EXTRA_OCTETS);
    assign o_reinit  = i_active && low_cnt == thresh;
    // a rising SYNC~ with a nonzero low run below the reinit threshold is an error report
    assign short_err = i_active && i_sync_n && low_cnt != '0 && low_cnt < thresh;
    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt        <= '0;
            o_sync_err     <= 1'b0;
            o_sync_err_cnt <= '0;
        end else begin
            low_cnt        <= (!i_active || i_sync_n) ? '0 : (low_cnt >= thresh ? thresh : low_cnt + 1'b1);
            o_sync_err     <= short_err;
            o_sync_err_cnt <= o_sync_err_cnt + ERR_CNT_W'(short_err && !(&o_sync_err_cnt));
        end
    end
endmodule

// File: rtl/jesd_tx_link_ctrl.sv
// jesd_tx_link_ctrl: multi-lane JESD204B TX link-layer controller (CGS, ILA, data phases)
//   i_lmfc_tick          LMFC boundary pulse
//   i_sync_n             synchronised SYNC~, active low
//   i_cfg_f/i_cfg_ila_mf octets per frame - 1 / ILA multiframes - 1, latched in SYNC
//   i_lane_en            per-lane enable; disabled lanes always send K
//   i_reg_link_test_*    link test sequence enable / type for the data phase
//   o_link_mux           3-bit octet-source select per lane (0 data, 1 K, 2 ILA, 3 test)
//   o_ila_mf_idx         ILA multiframe index
//   o_state/o_link_up    one-hot state / data phase indicator
//   o_sync_err(_cnt)     short SYNC~ error pulse and saturating count
module jesd_tx_link_ctrl
    import jesd_tx_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int F_MAX      = 16,
    parameter int ILA_MF_MAX = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_lmfc_tick,
    input  logic                            i_sync_n,
    input  logic [$clog2(F_MAX)-1:0]        i_cfg_f,
    input  logic [$clog2(ILA_MF_MAX)-1:0]   i_cfg_ila_mf,
    input  logic [LANES-1:0]                i_lane_en,
    input  logic                            i_reg_link_test_en,
    input  logic [1:0]                      i_reg_link_test_sel,
    output logic [3*LANES-1:0]              o_link_mux,
    output logic [1:0]                      o_link_test_sel,
    output logic [$clog2(ILA_MF_MAX)-1:0]   o_ila_mf_idx,
    output logic [2:0]                      o_state,
    output logic                            o_link_up,
    output logic                            o_sync_err,
    output logic [ERR_CNT_W-1:0]            o_sync_err_cnt
);
    localparam int FW = $clog2(F_MAX);
    localparam int MW = $clog2(ILA_MF_MAX);
    localparam int KW = $clog2(F_MAX + K_EXTRA_OCTETS + 1);
    state_t state, state_d;
    logic [FW-1:0] cfg_f_q, f_eff;
    logic [MW-1:0] cfg_mf_q, mf_eff, mf_cnt;
    logic [KW-1:0] k_cnt;
    logic [3*LANES-1:0] mux_d;
    logic in_sync, k_ok, reinit;
    assign in_sync = state == ST_SYNC;
    // config follows the inputs while in SYNC and is frozen everywhere else
    assign f_eff   = in_sync ? i_cfg_f : cfg_f_q;
    assign mf_eff  = in_sync ? i_cfg_ila_mf : cfg_mf_q;
    assign k_ok    = int'(k_cnt) >= int'(f_eff) + 1 + K_EXTRA_OCTETS;
    jesd_sync_n_monitor #(.F_MAX(F_MAX), .ERR_CNT_W(ERR_CNT_W)) u_mon (
        .clk            (clk),
        .rst            (rst),
        .i_active       (!in_sync),
        .i_sync_n       (i_sync_n),
        .i_cfg_f        (f_eff),
        .o_reinit       (reinit),
        .o_sync_err     (o_sync_err),
        .o_sync_err_cnt (o_sync_err_cnt)
    );
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_SYNC;
        else
            state <= state_d;
    end
    // reinit outranks any LMFC-driven transition in the same cycle
    always_comb begin
        state_d = reinit ? ST_SYNC
                : (in_sync && i_sync_n && k_ok && i_lmfc_tick) ? ST_INIT_LANE
                : (state == ST_INIT_LANE && i_lmfc_tick && mf_cnt == mf_eff) ? ST_DATA_ENC
                : state;
    end
    always_comb begin
        mux_d = '0;
        for (int i = 0; i < LANES; i++)
            mux_d[3*i +: 3] = (!i_lane_en[i] || in_sync) ? SEND_K
                            : state == ST_INIT_LANE ? SEND_LANE_SEQ
                            : i_reg_link_test_en ? SEND_LINK_TEST_SEQ : SEND_USER_DATA;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            k_cnt           <= '0;
            mf_cnt          <= '0;
            cfg_f_q         <= '0;
            cfg_mf_q        <= '0;
            o_link_mux      <= {LANES{SEND_K}};
            o_link_test_sel <= '0;
            o_link_up       <= 1'b0;
        end else begin
            k_cnt           <= (!in_sync || !i_sync_n) ? '0 : (&k_cnt ? k_cnt : k_cnt + 1'b1);
            mf_cnt          <= (state != ST_INIT_LANE || state_d != ST_INIT_LANE) ? '0 : mf_cnt + MW'(i_lmfc_tick);
            cfg_f_q         <= f_eff;
            cfg_mf_q        <= mf_eff;
            o_link_mux      <= mux_d;
            o_link_test_sel <= i_reg_link_test_sel;
            o_link_up       <= state == ST_DATA_ENC;
        end
    end
    assign o_state      = state;
    assign o_ila_mf_idx = mf_cnt;
endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// tb_jesd_tx_link_ctrl: directed and randomized checks of jesd_tx_link_ctrl against a behavioural model
module tb_jesd_tx_link_ctrl;
    localparam int LANES = 4;
    logic clk = 1'b0, rst = 1'b1, i_lmfc_tick = 1'b0, i_sync_n = 1'b0, i_reg_link_test_en = 1'b0;
    logic [3:0] i_cfg_f = 4'd1;
    logic [1:0] i_cfg_ila_mf = 2'd3;
    logic [3:0] i_lane_en = 4'hf;
    logic [1:0] i_reg_link_test_sel = 2'd0;
    logic [3*LANES-1:0] o_link_mux;
    logic [1:0] o_link_test_sel, o_ila_mf_idx;
    logic [2:0] o_state;
    logic o_link_up, o_sync_err;
    logic [7:0] o_sync_err_cnt;
    jesd_tx_link_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_lmfc_tick         (i_lmfc_tick),
        .i_sync_n            (i_sync_n),
        .i_cfg_f             (i_cfg_f),
        .i_cfg_ila_mf        (i_cfg_ila_mf),
        .i_lane_en           (i_lane_en),
        .i_reg_link_test_en  (i_reg_link_test_en),
        .i_reg_link_test_sel (i_reg_link_test_sel),
        .o_link_mux          (o_link_mux),
        .o_link_test_sel     (o_link_test_sel),
        .o_ila_mf_idx        (o_ila_mf_idx),
        .o_state             (o_state),
        .o_link_up           (o_link_up),
        .o_sync_err          (o_sync_err),
        .o_sync_err_cnt      (o_sync_err_cnt)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_err = 0;
    int m_ph, m_hi, m_low, m_mf, m_cf, m_cm, m_cnt, e_up, e_err, e_tsel;
    logic [3*LANES-1:0] e_mux;
    int tick_per = 32, tick_ctr = 0;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask
    // phases: 0 code-group sync, 1 ILA, 2 data; run lengths are plain unbounded counts
    task automatic model();
        int f, t, mm, nph;
        if (rst) begin
            m_ph = 0; m_hi = 0; m_low = 0; m_mf = 0; m_cf = 0; m_cm = 0; m_cnt = 0;
            e_mux = {LANES{3'd1}}; e_up = 0; e_err = 0; e_tsel = 0;
        end else begin
            f  = (m_ph == 0 ? int'(i_cfg_f) : m_cf) + 1;
            t  = 5 * f + 9;
            mm = m_ph == 0 ? int'(i_cfg_ila_mf) : m_cm;
            for (int i = 0; i < LANES; i++)
                e_mux[3*i +: 3] = (!i_lane_en[i] || m_ph == 0) ? 3'd1 : m_ph == 1 ? 3'd2 : i_reg_link_test_en ? 3'd3 : 3'd0;
            e_up   = m_ph == 2;
            e_tsel = i_reg_link_test_sel;
            e_err  = m_ph != 0 && i_sync_n && m_low > 0 && m_low < t;
            if (e_err && m_cnt < 255) m_cnt++;
            nph = m_ph;
            if (m_ph != 0 && m_low >= t) nph = 0;
            else if (m_ph == 0 && i_sync_n && i_lmfc_tick && m_hi >= f + 9) nph = 1;
            else if (m_ph == 1 && i_lmfc_tick && m_mf == mm) nph = 2;
            m_hi  = (m_ph == 0 && i_sync_n) ? m_hi + 1 : 0;
            m_low = (m_ph != 0 && !i_sync_n) ? m_low + 1 : 0;
            m_mf  = (m_ph == 1 && nph == 1) ? m_mf + int'(i_lmfc_tick) : 0;
            if (m_ph == 0) begin
                m_cf = i_cfg_f;
                m_cm = i_cfg_ila_mf;
            end
            m_ph = nph;
        end
    endtask
    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model();
            #1;
            chk("state", o_state, 32'(1 << m_ph));
            chk("mux", o_link_mux, e_mux);
            chk("link_up", o_link_up, e_up);
            chk("sync_err", o_sync_err, e_err);
            chk("err_cnt", o_sync_err_cnt, m_cnt);
            chk("ila_idx", o_ila_mf_idx, m_mf);
            chk("test_sel", o_link_test_sel, e_tsel);
            tick_ctr    = (tick_ctr + 1) % tick_per;
            i_lmfc_tick = tick_ctr == tick_per - 1;
        end
    endtask
    task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
        for (int k = 0; k < lim && o_state !== s; k++) step(1);
        chk(tag, o_state, s);
    endtask
    task automatic wait_ctr(input int v);
        for (int k = 0; k < 64 && tick_ctr != v; k++) step(1);
        chk("tick_align", tick_ctr, v);
    endtask
    initial begin
        step(3);
        chk("rst_state", o_state, 3'b001);
        chk("rst_mux", o_link_mux, 12'h249);
        rst = 1'b0;
        step(97);
        i_sync_n = 1'b1;
        wait_state(3'b010, 200, "enter_ila");
        step(1);
        chk("ila_mux", o_link_mux, 12'h492);
        wait_state(3'b100, 300, "enter_data");
        step(1);
        chk("link_up", o_link_up, 1);
        i_sync_n = 1'b0; step(10); i_sync_n = 1'b1; step(2);
        chk("short_cnt", o_sync_err_cnt, 1);
        chk("short_state", o_state, 3'b100);
        i_sync_n = 1'b0; step(19); i_sync_n = 1'b1; step(2);
        chk("reinit_state", o_state, 3'b001);
        chk("reinit_mux", o_link_mux, 12'h249);
        chk("reinit_cnt", o_sync_err_cnt, 1);
        wait_state(3'b100, 400, "redata");
        i_lane_en = 4'b0101; i_reg_link_test_en = 1'b1; i_reg_link_test_sel = 2'd2;
        step(2);
        chk("lane_mask_mux", o_link_mux, 12'h2cb);
        chk("test_sel_reg", o_link_test_sel, 2);
        i_lane_en = 4'hf;
        i_sync_n = 1'b0; step(25); i_sync_n = 1'b1;
        wait_state(3'b010, 200, "ila_again");
        wait_ctr(12);
        i_sync_n = 1'b0; step(20); i_sync_n = 1'b1; step(1);
        chk("reinit_vs_tick", o_state, 3'b001);
        i_cfg_ila_mf = 2'd0;
        wait_state(3'b010, 200, "ila_short");
        wait_ctr(29);
        i_sync_n = 1'b0; step(5); i_sync_n = 1'b1; step(2);
        chk("ila_end_low_state", o_state, 3'b100);
        chk("ila_end_low_cnt", o_sync_err_cnt, 2);
        for (int k = 0; k < 300; k++) begin
            i_sync_n = 1'b0; step(2); i_sync_n = 1'b1; step(2);
        end
        chk("err_saturate", o_sync_err_cnt, 255);
        i_sync_n = 1'b0; step(25); i_cfg_ila_mf = 2'd3; i_sync_n = 1'b1;
        wait_state(3'b010, 200, "ila_for_rst");
        for (int k = 0; k < 100 && o_ila_mf_idx != 2'd2; k++) step(1);
        chk("ila_idx2", o_ila_mf_idx, 2);
        rst = 1'b1; step(1);
        chk("mid_rst_state", o_state, 3'b001);
        chk("mid_rst_mux", o_link_mux, 12'h249);
        chk("mid_rst_cnt", o_sync_err_cnt, 0);
        chk("mid_rst_idx", o_ila_mf_idx, 0);
        chk("mid_rst_up", o_link_up, 0);
        rst = 1'b0;
        for (int s = 0; s < 40; s++) begin
            tick_per = 8 << $urandom_range(0, 2);
            tick_ctr = 0;
            i_cfg_f = 4'($urandom);
            i_cfg_ila_mf = 2'($urandom);
            i_lane_en = 4'($urandom);
            i_reg_link_test_en = 1'($urandom);
            i_reg_link_test_sel = 2'($urandom);
            rst = $urandom_range(0, 19) == 0;
            step(1);
            rst = 1'b0;
            i_sync_n = 1'b0; step($urandom_range(1, 100));
            i_sync_n = 1'b1; step($urandom_range(1, 250));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
